// File: rtl/clocked_ff_pkg.sv
// Shared types and the next-state rule for the emulated flip-flop bank.
package clocked_ff_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {FF_SR, FF_JK, FF_D, FF_T} ff_mode_e;
  typedef enum logic       {EDGE_FALL, EDGE_RISE}     ff_edge_e;
  typedef enum logic [1:0] {SRB_HOLD, SRB_RESET, SRB_SET} sr_both_e;

  // j doubles as S/J/D/T, k as R/K depending on mode.
  function automatic logic ff_next(ff_mode_e mode, sr_both_e srb,
                                   logic q, logic j, logic k);
    logic n;
    n = q;
    case (mode)
      FF_SR: case ({j, k})
        2'b10:   n = 1'b1;
        2'b01:   n = 1'b0;
        2'b11:   n = (srb == SRB_RESET) ? 1'b0 : (srb == SRB_SET) ? 1'b1 : q;
        default: n = q;
      endcase
      FF_JK: case ({j, k})
        2'b10:   n = 1'b1;
        2'b01:   n = 1'b0;
        2'b11:   n = ~q;
        default: n = q;
      endcase
      FF_D:    n = j;
      FF_T:    n = j ? ~q : q;
      default: n = q;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/clocked_ff_cell.sv
// One flip-flop channel: async preset/clear emulated synchronously on clk.
module clocked_ff_cell
  import clocked_ff_pkg::*;
#(
  parameter ff_mode_e MODE    = FF_JK,
  parameter sr_both_e SR_BOTH = SRB_HOLD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hit,
  input  logic pre_n,
  input  logic clr_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_n
);

  logic state;
  logic nxt;

  // Both outputs high means preset+clear was active; the stored state is then 0.
  assign state = q & ~q_n;

  always_comb begin
    nxt = state;
    if (hit) nxt = ff_next(MODE, SR_BOTH, state, j, k);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= 1'b0;
      q_n <= 1'b1;
    end else if (!pre_n && !clr_n) begin
      q   <= 1'b1;
      q_n <= 1'b1;
    end else if (!clr_n) begin
      q   <= 1'b0;
      q_n <= 1'b1;
    end else if (!pre_n) begin
      q   <= 1'b1;
      q_n <= 1'b0;
    end else begin
      q   <= nxt;
      q_n <= ~nxt;
    end
  end

endmodule

// File: rtl/clocked_ff_bank.sv
// Bank of flip-flops clocked by an emulated CLK_N, oversampled on CLK_DRV.
module clocked_ff_bank
  import clocked_ff_pkg::*;
#(
  parameter int       WIDTH   = 4,
  parameter ff_mode_e MODE    = FF_JK,
  parameter ff_edge_e EDGE    = EDGE_FALL,
  parameter sr_both_e SR_BOTH = SRB_HOLD
) (
  input  logic             CLK_DRV,
  input  logic             RESET_N,
  input  logic             CLK_N,
  input  logic [WIDTH-1:0] PRE_N,
  input  logic [WIDTH-1:0] CLR_N,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_N
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("clocked_ff_bank: WIDTH out of range");
  end

  logic clk_n_d;
  logic armed;
  logic hit;

  // armed keeps the reset value of clk_n_d from looking like an edge.
  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_n_d <= 1'b0;
      armed   <= 1'b0;
    end else begin
      clk_n_d <= CLK_N;
      armed   <= 1'b1;
    end
  end

  assign hit = armed && ((EDGE == EDGE_FALL) ? (clk_n_d && !CLK_N)
                                             : (!clk_n_d && CLK_N));

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    clocked_ff_cell #(
      .MODE    (MODE),
      .SR_BOTH (SR_BOTH)
    ) u_cell (
      .clk   (CLK_DRV),
      .rst_n (RESET_N),
      .hit   (hit),
      .pre_n (PRE_N[i]),
      .clr_n (CLR_N[i]),
      .j     (J[i]),
      .k     (K[i]),
      .q     (Q[i]),
      .q_n   (Q_N[i])
    );
  end

endmodule

// File: doc/clocked_ff_bank.md
CLOCKED_FF_BANK -- requirements
Module: clocked_ff_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the number of independent flip-flop channels (legal 1..32).
REQ-002 The block SHALL have parameter MODE, default FF_JK, meaning the per-bank next-state rule (FF_SR, FF_JK, FF_D, FF_T).
REQ-003 The block SHALL have parameter EDGE, default EDGE_FALL, meaning the active transition of CLK_N (EDGE_FALL, EDGE_RISE).
REQ-004 The block SHALL have parameter SR_BOTH, default SRB_HOLD, meaning the SR-mode response to S=R=1 (SRB_HOLD, SRB_RESET, SRB_SET).
REQ-005 CLK_DRV  input  1  sole clock; all state updates on its rising edge.
REQ-006 RESET_N  input  1  reset, asynchronous, active-low.
REQ-007 CLK_N  input  1  emulated logic clock, sampled on CLK_DRV, shared by all channels.
REQ-008 PRE_N  input  WIDTH  per-channel active-low preset.
REQ-009 CLR_N  input  WIDTH  per-channel active-low clear.
REQ-010 J  input  WIDTH  S/J/D/T data per MODE.
REQ-011 K  input  WIDTH  R/K data; ignored in FF_D and FF_T.
REQ-012 Q  output  WIDTH  registered true output.
REQ-013 Q_N  output  WIDTH  registered complement output.

Function
REQ-014 An active edge SHALL be detected in the CLK_DRV cycle where CLK_N differs from its one-cycle-delayed copy in the EDGE direction.
REQ-015 Q SHALL update at the same CLK_DRV rising edge that detects the active edge, using J/K present at that edge (latency 1 CLK_DRV edge from CLK_N change).
REQ-016 FF_SR: S=1,R=0 -> 1; S=0,R=1 -> 0; 0,0 -> hold; 1,1 -> per SR_BOTH (hold / 0 / 1).
REQ-017 FF_JK: 1,0 -> 1; 0,1 -> 0; 0,0 -> hold; 1,1 -> toggle.
REQ-018 FF_D: Q takes J; FF_T: J=1 toggles, J=0 holds.
REQ-019 Per-channel priority per CLK_DRV edge SHALL be: PRE_N=0 and CLR_N=0 > CLR_N=0 > PRE_N=0 > active edge > hold.
REQ-020 PRE_N/CLR_N SHALL act on every CLK_DRV edge regardless of CLK_N, taking effect at the next CLK_DRV rising edge.
REQ-021 With PRE_N=CLR_N=0 on a channel, Q and Q_N SHALL both be 1; internal state SHALL be 0, so after simultaneous release Q=0, Q_N=1.
REQ-022 Outside REQ-021, Q_N SHALL always equal ~Q.
REQ-023 An active edge coinciding with PRE_N=0 or CLR_N=0 on a channel SHALL be ignored for that channel only.
REQ-024 Channels SHALL be fully independent except for the shared CLK_N edge.

Reset
REQ-025 While RESET_N=0: Q=0, Q_N=1, edge-detect history cleared, arm flag cleared.
REQ-026 Edge detection SHALL be suppressed in the first CLK_DRV cycle after RESET_N deasserts (arm flag), preventing a spurious edge from the reset value of the delayed CLK_N copy.
REQ-027 RESET_N asserted mid-operation SHALL override all inputs immediately, without waiting for CLK_DRV.

Structure
REQ-028 Package clocked_ff_pkg SHALL hold the ff_mode_e, ff_edge_e and sr_both_e enums and the WIDTH limit constant.
REQ-029 One sub-module, clocked_ff_cell, SHALL implement a single channel's next-state and PRE/CLR logic; the top SHALL hold the shared edge detector, arm flag and the generate loop.

Verification
REQ-030 JK, WIDTH=4, falling edge, J=4'b0101 K=4'b0010 from reset -> after first CLK_N fall Q=4'b0101, Q_N=4'b1010; next fall with J=K=4'b1111 -> Q=4'b1010.
REQ-031 SR, SR_BOTH=SRB_RESET, Q=4'b1111, S=R=4'b0011 on a fall -> Q=4'b1100; same with SRB_HOLD -> Q unchanged at 4'b1111.
REQ-032 PRE_N=4'b1110 held across two CLK_N falls with K=4'b1111 -> Q[0]=1 throughout, Q[3:1]=0 after first fall.
REQ-033 PRE_N=CLR_N=4'b1110 -> Q[0]=Q_N[0]=1; release both together -> Q[0]=0, Q_N[0]=1 next CLK_DRV edge.
REQ-034 RESET_N released while CLK_N=0 after CLK_N=1 in reset, EDGE_FALL -> no Q change in first cycle; next real fall updates Q.
REQ-035 FF_T, EDGE_RISE, J=4'b1000, 3 CLK_N rises -> Q[3] toggles 1,0,1; RESET_N pulsed mid-run -> Q=0 immediately.
